// File: rtl/seq_multiplier.sv
// Sequential 8x8 shift-and-add multiplier built around a single ripple-carry byte adder.
// Define MUL_SIGNED_EN for two's-complement operands (magnitude multiply, sign applied at the end).
module seq_multiplier (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   output logic [15:0] P,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q, state_d;
   logic [7:0]  m_q, m_d;
   logic [7:0]  acc_q, acc_d;
   logic [7:0]  q_q, q_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] p_q, p_d;

   logic [7:0]  addend;
   logic [7:0]  sum;
   logic [8:0]  carry;
   logic        cout;
   logic [15:0] prod_next;
   logic [7:0]  a_cap;
   logic [7:0]  b_cap;

`ifdef MUL_SIGNED_EN
   logic        neg_q, neg_d;

   // Magnitudes fit in 8 unsigned bits; -128 becomes 0x80.
   assign a_cap = A[7] ? (~A + 8'd1) : A;
   assign b_cap = B[7] ? (~B + 8'd1) : B;
`else
   assign a_cap = A;
   assign b_cap = B;
`endif

   // The one byte adder: ACC + (Q[0] ? M : 0), carry-in tied low.
   always_comb begin
      addend   = q_q[0] ? m_q : 8'd0;
      sum      = 8'd0;
      carry    = 9'd0;
      carry[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sum[i]       = acc_q[i] ^ addend[i] ^ carry[i];
         carry[i + 1] = (acc_q[i] & addend[i]) | (carry[i] & (acc_q[i] ^ addend[i]));
      end
      cout      = carry[8];
      prod_next = {cout, sum, q_q[7:1]};
   end

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      acc_d   = acc_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
`ifdef MUL_SIGNED_EN
      neg_d   = neg_q;
`endif
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               m_d     = a_cap;
               q_d     = b_cap;
               acc_d   = 8'd0;
               cnt_d   = 3'd0;
`ifdef MUL_SIGNED_EN
               neg_d   = A[7] ^ B[7];
`endif
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            {acc_d, q_d} = prod_next;
            cnt_d        = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
`ifdef MUL_SIGNED_EN
               p_d = neg_q ? (~prod_next + 16'd1) : prod_next;
`else
               p_d = prod_next;
`endif
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         m_q     <= 8'd0;
         acc_q   <= 8'd0;
         q_q     <= 8'd0;
         cnt_q   <= 3'd0;
         p_q     <= 16'd0;
`ifdef MUL_SIGNED_EN
         neg_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
`ifdef MUL_SIGNED_EN
         neg_q   <= neg_d;
`endif
      end
   end

   assign P    = p_q;
   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: cycle-level reference model plus directed literal checks.
// Build with MUL_SIGNED_EN defined to exercise the two's-complement variant.
module tb_seq_multiplier;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [15:0] P;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;
   int modelOn = 0;

   int          k = -1;
   logic [15:0] expP = 16'd0;
   logic [15:0] pending = 16'd0;

   int latency;
   int busyCount;

   seq_multiplier dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .P     (P),
      .busy  (busy),
      .done  (done)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Arithmetic reference product for the configured operand interpretation.
   function automatic logic [15:0] refProduct(input logic [7:0] a, input logic [7:0] b);
      logic signed [15:0] sa;
      logic signed [15:0] sb;
      logic [15:0]        ua;
      logic [15:0]        ub;
`ifdef MUL_SIGNED_EN
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      ua = 16'd0;
      ub = 16'd0;
      return sa * sb;
`else
      sa = 16'sd0;
      sb = 16'sd0;
      ua = {8'd0, a};
      ub = {8'd0, b};
      return ua * ub;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h at time %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: k counts edges since the accepting edge (-1 when idle).
   // busy for k=0..7, done at k=8, P takes the product when k reaches 8.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         k    = -1;
         expP = 16'd0;
      end else begin
         if (k == -1 || k == 8) begin
            if (start) begin
               k       = 0;
               pending = refProduct(A, B);
            end else begin
               k = -1;
            end
         end else begin
            k = k + 1;
            if (k == 8) expP = pending;
         end
      end
   end

   // Per-cycle comparison of every output against the model, just after each edge.
   always @(posedge clk) begin
      #1;
      if (!rst && modelOn != 0) begin
         checkOutput("cycleBusy", {15'd0, busy}, {15'd0, (k >= 0 && k <= 7)});
         checkOutput("cycleDone", {15'd0, done}, {15'd0, (k == 8)});
         checkOutput("cycleP", P, expP);
      end
   end

   // Present operands with start for one edge; returns on the falling edge after acceptance.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
      A     = a;
      B     = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called on the falling edge after the accept edge; bounded wait for done.
   task automatic waitDone(output int lat, output int busyCnt);
      lat     = 1;
      busyCnt = 0;
      for (int n = 0; n < 30 && !done; n++) begin
         if (busy) busyCnt++;
         @(negedge clk);
         lat++;
      end
      checkOutput("doneSeen", {15'd0, done}, 16'd1);
   endtask

   task automatic runOp(input logic [7:0] a, input logic [7:0] b, input logic [15:0] expected, input string name);
      applyStimulus(a, b);
      waitDone(latency, busyCount);
      checkOutput(name, P, expected);
      checkOutput({name, "Latency"}, 16'(latency), 16'd9);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time %0t exceeded limit 200000", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      A     = 8'd0;
      B     = 8'd0;
      repeat (2) @(negedge clk);
      checkOutput("resetP", P, 16'h0000);
      checkOutput("resetBusy", {15'd0, busy}, 16'd0);
      checkOutput("resetDone", {15'd0, done}, 16'd0);
      rst     = 1'b0;
      modelOn = 1;
      @(negedge clk);

      $display("[TB] 13 x 11 with latency and busy-width checks");
      applyStimulus(8'd13, 8'd11);
      waitDone(latency, busyCount);
      checkOutput("p13x11", P, 16'h008F);
      checkOutput("latency13x11", 16'(latency), 16'd9);
      checkOutput("busyCycles13x11", 16'(busyCount), 16'd8);
      repeat (4) @(negedge clk);
      checkOutput("holdP", P, 16'h008F);
      checkOutput("idleBusy", {15'd0, busy}, 16'd0);

`ifndef MUL_SIGNED_EN
      runOp(8'd255, 8'd255, 16'hFE01, "p255x255");
`endif
      runOp(8'd0, 8'hA5, 16'h0000, "p0xA5");
      runOp(8'd1, 8'd1, 16'h0001, "p1x1");

      $display("[TB] back-to-back with start held high");
      A     = 8'd2;
      B     = 8'd3;
      start = 1'b1;
      @(negedge clk);
      A = 8'd99;
      B = 8'd77;
      waitDone(latency, busyCount);
      checkOutput("b2bFirst", P, 16'h0006);
      A = 8'd4;
      B = 8'd5;
      @(negedge clk);
      A = 8'd11;
      B = 8'd13;
      waitDone(latency, busyCount);
      checkOutput("b2bSecond", P, 16'h0014);
      checkOutput("b2bLatency", 16'(latency), 16'd9);
      start = 1'b0;
      @(negedge clk);

      $display("[TB] reset during iteration 4");
      applyStimulus(8'd200, 8'd100);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("midResetP", P, 16'h0000);
      checkOutput("midResetBusy", {15'd0, busy}, 16'd0);
      checkOutput("midResetDone", {15'd0, done}, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("postResetP", P, 16'h0000);
      runOp(8'd7, 8'd6, 16'h002A, "p7x6");

`ifdef MUL_SIGNED_EN
      $display("[TB] signed operand cases");
      runOp(8'hFD, 8'd5, 16'hFFF1, "sNeg3x5");
      runOp(8'h80, 8'h80, 16'h4000, "sNeg128xNeg128");
      runOp(8'h80, 8'h7F, 16'hC080, "sNeg128x127");
      runOp(8'h7F, 8'hFF, 16'hFF81, "s127xNeg1");
`endif

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential 8x8 shift-and-add multiplier for the ALU's multiply path. It reuses one 8-bit ripple-carry byte adder (carry-in tied 0) as its only arithmetic element and performs one add/shift step per clock. It sits directly downstream of the ALU operand registers and feeds its 16-bit product to the ALU result mux. A start/busy/done handshake fixes the latency at 9 cycles.

## Interface
- Parameters: none. Width is fixed at 8 to match the byte adder.
- clk  in  1  rising-edge clock
- rst  in  1  reset: asynchronous, active-high; clears all state
- start  in  1  request; sampled only in IDLE or DONE
- A  in  8  multiplicand; captured when start is accepted
- B  in  8  multiplier; captured when start is accepted
- P  out  16  product register; holds its value until the next completion
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse in DONE; P is valid from this cycle

## Operation
- Internal registers:
  - M[7:0]: multiplicand.
  - ACC[7:0]: upper partial product.
  - Q[7:0]: multiplier, which becomes the lower partial product.
  - CNT[2:0]: iteration counter.
  - state: IDLE, RUN or DONE.
- Reset values: state=IDLE, P=0, busy=0, done=0, and M, ACC, Q, CNT all 0.
- IDLE:
  - With start=1: M<=A, Q<=B, ACC<=0, CNT<=0, then go to RUN.
  - Otherwise hold.
- RUN, on each edge:
  - Adder computes {cout,S} = ACC + (Q[0] ? M : 0).
  - {ACC,Q} <= {cout,S,Q[7:1]}, which is a 17-bit value shifted right by 1.
  - CNT <= CNT+1.
  - When CNT==7, P <= final {ACC,Q} (the post-shift value) and the state goes to DONE.
  - CNT wraps 7->0.
- DONE:
  - done=1 for exactly one cycle.
  - With start=1: capture A/B and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- start while in RUN is ignored. It is not queued.
- A and B may change freely after capture without affecting the result.
- Arithmetic is unsigned by default. The 16-bit product cannot overflow (max 255*255 = 0xFE01).

## Timing
- Edge E0 (start=1 in IDLE): operand capture. Edges E1..E8: the eight iterations.
- busy=1 from after E0 until after E8. That is 8 cycles.
- P is updated at E8. done=1 in the cycle following E8.
- Latency is 9 cycles from the start-accept edge to done.
- Back-to-back throughput: one product every 9 cycles.
- rst asserted mid-operation clears everything immediately, regardless of clk. The operation is lost and P reads 0.
- After rst deasserts, the first start is accepted on the next edge.

## Configuration
- MUL_SIGNED_EN, defined:
  - Operands are two's complement.
  - On capture: M<=|A|, Q<=|B|, and NEG<=A[7]^B[7]. |-128| is 128 (0x80 as unsigned magnitude).
  - At E8: P <= NEG ? -{ACC,Q} : {ACC,Q}, as a 16-bit two's-complement negate.
  - Timing is unchanged.
- MUL_SIGNED_EN undefined:
  - Unsigned only. The NEG register and the abs/negate logic are not compiled.

## Test plan
- Reset, then A=13, B=11, start for 1 cycle -> busy high for 8 cycles, done pulse 9 cycles after the accept edge, P=0x008F. Then idle with P held.
- A=255, B=255 -> P=0xFE01. A=0, B=0xA5 -> P=0x0000. A=1, B=1 -> P=0x0001.
- start held high continuously with A=2, B=3, then A=4, B=5 at the DONE cycle -> P=0x0006, then P=0x0014. Operands presented during RUN are ignored.
- Start A=200, B=100, assert rst at iteration 4 -> P=0, busy=0, done=0 immediately. Then a new start with A=7, B=6 -> P=0x002A.
- With MUL_SIGNED_EN: A=-3, B=5 -> P=0xFFF1. A=-128, B=-128 -> P=0x4000. A=-128, B=127 -> P=0xC080. A=127, B=-1 -> P=0xFF81.
